// File: rtl/fruit_pkg.sv
// Shared widths, spawn FSM encodings and the saturating score helper
// for the fruit spawner and its slots.
package fruit_pkg;

  localparam int COORD_W = 5;
  localparam int SCORE_W = 8;
  localparam int KCNT_W  = 4;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DRAW_X   = 2'd1;
  localparam logic [1:0] ST_DRAW_GAP = 2'd2;
  localparam logic [1:0] ST_WAIT     = 2'd3;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [KCNT_W-1:0]  b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {{(SCORE_W+1-KCNT_W){1'b0}}, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/fruit_slot.sv
// One fruit slot: holds position, rises on frame ticks, and reports
// whether it was sliced (kill) or escaped past the top row (lost).
module fruit_slot
  import fruit_pkg::*;
#(
  parameter int TOP_ROW   = 31,
  parameter int SLICE_MIN = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_spawn,
  input  logic [COORD_W-1:0] i_spawn_x,
  input  logic               i_tick,
  input  logic               i_slice_valid,
  input  logic [COORD_W-1:0] i_slice_x,
  output logic               o_active,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_kill,
  output logic               o_lost
);

  logic               r_active;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               w_kill;
  logic               w_lost;

  // A slice is judged on the pre-tick row and beats an escape in the same cycle.
  assign w_kill = r_active && i_slice_valid && (r_x == i_slice_x) &&
                  (r_y >= COORD_W'(SLICE_MIN));
  assign w_lost = r_active && i_tick && (r_y == COORD_W'(TOP_ROW)) && !w_kill;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_active <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
    end else if (w_kill || w_lost) begin
      r_active <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
    end else if (i_spawn) begin
      r_active <= 1'b1;
      r_x      <= i_spawn_x;
      r_y      <= '0;
    end else if (r_active && i_tick) begin
      r_y <= r_y + 1'b1;
    end
  end

  assign o_active = r_active;
  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_kill   = w_kill;
  assign o_lost   = w_lost;

endmodule

// File: rtl/fruit_spawner.sv
// Spawn FSM drawing column and gap from the random stream, a pool of
// rising fruit slots, and slice/miss resolution with a saturating score.
module fruit_spawner
  import fruit_pkg::*;
#(
  parameter int N_SLOTS   = 4,
  parameter int TOP_ROW   = 31,
  parameter int SLICE_MIN = 4,
  parameter int MIN_GAP   = 2
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic [COORD_W-1:0]           i_rnd_num,
  input  logic                         i_rnd_valid,
  input  logic                         i_tick,
  input  logic                         i_slice_valid,
  input  logic [COORD_W-1:0]           i_slice_x,
  output logic [N_SLOTS-1:0]           o_slot_active,
  output logic [COORD_W*N_SLOTS-1:0]   o_slot_x,
  output logic [COORD_W*N_SLOTS-1:0]   o_slot_y,
  output logic                         o_rnd_take,
  output logic                         o_hit,
  output logic                         o_miss,
  output logic [SCORE_W-1:0]           o_score
);

  localparam int GAP_W = 8;

  logic [1:0]         r_state;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [SCORE_W-1:0] r_score;

  logic [N_SLOTS-1:0] w_active;
  logic [N_SLOTS-1:0] w_spawn;
  logic [N_SLOTS-1:0] w_kill;
  logic [N_SLOTS-1:0] w_lost;
  logic               w_draw_x;
  logic               w_take_x;
  logic               w_take_gap;
  logic               w_found;
  logic [KCNT_W-1:0]  w_kill_cnt;

  assign w_draw_x   = (r_state == ST_DRAW_X) && i_enable && i_rnd_valid;
  assign w_take_x   = w_draw_x && !(&w_active);
  assign w_take_gap = (r_state == ST_DRAW_GAP) && i_enable && i_rnd_valid;

  // Lowest free slot wins, using occupancy from the start of the cycle.
  always_comb begin
    w_spawn = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!w_found && !w_active[i]) begin
        w_spawn[i] = w_draw_x;
        w_found    = 1'b1;
      end
    end
  end

  always_comb begin
    w_kill_cnt = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_kill_cnt = w_kill_cnt + {{(KCNT_W-1){1'b0}}, w_kill[i]};
    end
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    fruit_slot #(
      .TOP_ROW  (TOP_ROW),
      .SLICE_MIN(SLICE_MIN)
    ) u_slot (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_spawn      (w_spawn[g]),
      .i_spawn_x    (i_rnd_num),
      .i_tick       (i_tick),
      .i_slice_valid(i_slice_valid),
      .i_slice_x    (i_slice_x),
      .o_active     (w_active[g]),
      .o_x          (o_slot_x[COORD_W*g +: COORD_W]),
      .o_y          (o_slot_y[COORD_W*g +: COORD_W]),
      .o_kill       (w_kill[g]),
      .o_lost       (w_lost[g])
    );
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
      r_score   <= '0;
    end else begin
      r_score <= sat_add(r_score, w_kill_cnt);
      if (!i_enable) begin
        r_state   <= ST_IDLE;
        r_gap_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE:     r_state <= ST_DRAW_X;
          ST_DRAW_X:   if (w_take_x) r_state <= ST_DRAW_GAP;
          ST_DRAW_GAP: if (w_take_gap) begin
            r_gap_cnt <= GAP_W'(MIN_GAP) + {{(GAP_W-3){1'b0}}, i_rnd_num[2:0]};
            r_state   <= ST_WAIT;
          end
          ST_WAIT:     if (i_tick) begin
            if (r_gap_cnt == GAP_W'(1)) r_state <= ST_DRAW_X;
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
          default:     r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_slot_active = w_active;
  assign o_rnd_take    = w_take_x || w_take_gap;
  assign o_hit         = |w_kill;
  assign o_miss        = |w_lost;
  assign o_score       = r_score;

endmodule

// File: doc/fruit_spawner.md
# fruit_spawner

Consumer end of the 5-bit LCG random stream. Pulls random values to pick spawn column and inter-spawn gap, manages a fixed pool of fruit slots rising one row per frame tick, and resolves player slices into hits, misses and a saturating score. Sits between the random number generator and the display/scoring logic of the game.

## Interface
Parameters:
- N_SLOTS, 4, number of concurrent fruit slots (1..8)
- TOP_ROW, 31, row at which an unsliced fruit is lost (≤31)
- SLICE_MIN, 4, minimum row for a fruit to be sliceable
- MIN_GAP, 2, minimum ticks between spawns (≥1)

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  game running; low halts new spawns only
- rnd_num  in  5  current random value from the generator
- rnd_valid  in  1  rnd_num is meaningful this cycle (generator seeded)
- tick  in  1  one-cycle frame pulse
- slice_valid  in  1  one-cycle slice event
- slice_x  in  5  column of slice
- slot_active  out  N_SLOTS  per-slot occupied flag
- slot_x  out  5*N_SLOTS  column per slot, slot i at [5i+4:5i]
- slot_y  out  5*N_SLOTS  row per slot, same packing
- rnd_take  out  1  high in any cycle rnd_num is consumed
- hit  out  1  pulse, ≥1 fruit sliced this cycle
- miss  out  1  pulse, ≥1 fruit reached TOP_ROW this cycle
- score  out  8  hits so far, saturates at 255

## Operation
- Spawn FSM states: IDLE, DRAW_X, DRAW_GAP, WAIT.
- IDLE: enable=1 -> DRAW_X.
- DRAW_X: when rnd_valid and any slot free: lowest-index free slot gets active=1, x=rnd_num, y=0; rnd_take=1; -> DRAW_GAP. No free slot or rnd_valid=0: stay, rnd_take=0.
- DRAW_GAP: when rnd_valid: gap_cnt = MIN_GAP + rnd_num[2:0]; rnd_take=1; -> WAIT. Else stay.
- WAIT: on tick, gap_cnt==1 -> DRAW_X, else gap_cnt decrements. Non-tick cycles hold.
- enable=0 in any state -> IDLE next cycle, gap_cnt cleared; slots keep moving and remain sliceable.
- Slot update on tick: active slots with y<TOP_ROW increment y; active slot with y==TOP_ROW clears active, contributes to miss.
- Slice: every active slot with x==slice_x and y≥SLICE_MIN clears active; hit=1; score += number killed, saturating at 255.
- Slice and tick same cycle: slice evaluated on pre-tick y and wins; a killed slot neither moves nor misses.
- Spawn uses free flags from the start of the cycle; a slot freed by miss/slice this cycle is not reusable until next cycle.
- Inactive slots hold x and y at 0.

## Timing
- Reset values: state IDLE, gap_cnt 0, all slot_active/slot_x/slot_y 0, rnd_take 0, hit 0, miss 0, score 0.
- rnd_take, hit, miss combinational from current state and inputs; all other outputs registered.
- First spawn: earliest cycle after enable rises = IDLE->DRAW_X edge, spawn visible on slot outputs the following edge.
- Two consecutive draws use values from two consecutive cycles (generator advances every clock).
- Spawn-to-spawn period = 2 cycles of draw + gap_cnt ticks.
- hit/miss visible same cycle as the triggering slice/tick; slot_active drop and score update one edge later.

## Structure
- fruit_pkg: COORD_W=5, SCORE_W=8, spawn state enum, saturating-add helper.
- Sub-module fruit_slot (one instance per slot): holds active/x/y, takes spawn, tick, slice inputs, outputs kill and lost flags. Top holds FSM, free-slot priority encoder, hit/miss reduction, score.

## Test plan
- Reset then enable=1, rnd_valid=1, rnd_num sequence 7,3: slot0 active x=7 y=0; gap_cnt=MIN_GAP+3=5; next spawn after 5 ticks.
- Spawned fruit, 32 ticks no slice: y reaches 31, next tick miss=1, slot0 inactive, score unchanged.
- Fruit x=9 y=4, slice_valid slice_x=9 with tick same cycle: hit=1, slot freed, y not incremented, score=1; same at y=3 -> no hit.
- All 4 slots full at gap expiry: FSM stays DRAW_X, rnd_take=0; slice frees slot2 -> spawn into slot2 next cycle.
- rnd_valid=0 for 10 cycles in DRAW_X: no spawn, no rnd_take; rnd_valid=1 -> spawn.
- Score at 255 plus two-slot hit same cycle: score stays 255, hit=1; enable low mid-WAIT -> IDLE, fruits still rise.
